// File: rtl/lgn_frame_ctrl.sv
// Frame sequencer between the host pads and the logic-gate-network core.
// Synchronises the host byte strobe and forwards each byte to the core as a
// one-cycle write. After the last byte of a frame it waits out the core's
// fixed latency, then latches the class-score word and holds it for readout.
module lgn_frame_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_WORDS = 98,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned INFER_LAT = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_strobe,
  input  logic [DATA_W-1:0] host_data,
  output logic              lgn_we,
  output logic [DATA_W-1:0] lgn_data,
  input  logic [OUT_W-1:0]  lgn_out,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned ByteW = $clog2(NUM_WORDS + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam int unsigned LatW  = $clog2(INFER_LAT + 1);

  localparam logic [ByteW-1:0] ByteLast = ByteW'(NUM_WORDS);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);
  localparam logic [LatW-1:0]  LatLast  = LatW'(INFER_LAT - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

  state_e state_q, state_d;

  // Strobe synchroniser, edge detector and byte capture.
  logic              s1_q, s2_q, s3_q;
  logic              ev, ev_q;
  logic [DATA_W-1:0] hd_q, pend_q;

  logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d, byte_inc;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d, idle_inc;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;

  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [OUT_W-1:0]  res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              err_q, err_d;

  // A strobe held high gives a single event: only the 0->1 transition counts.
  assign ev       = s2_q & ~s3_q;
  assign byte_inc = byte_cnt_q + ByteW'(1);
  // Idle counter saturates at TIMEOUT.
  assign idle_inc = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleW'(1);

  // Synchronise the pad strobe and capture pad data while it is known stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      ev_q   <= 1'b0;
      hd_q   <= '0;
      pend_q <= '0;
    end else begin
      s1_q <= host_strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
      ev_q <= ev;
      // hd_q was sampled one cycle after the strobe was first seen, well
      // inside the window where the host holds the data steady.
      hd_q <= host_data;
      if (ev) begin
        pend_q <= hd_q;
      end
    end
  end

  // Frame sequencing: next state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    we_d        = 1'b0;
    data_d      = data_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (ev_q) begin
          we_d        = 1'b1;
          data_d      = pend_q;
          byte_cnt_d  = ByteW'(1);
          idle_cnt_d  = '0;
          lat_cnt_d   = '0;
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          state_d     = (ByteW'(1) == ByteLast) ? StWait : StLoad;
        end
      end
      StLoad: begin
        // An event on the timeout cycle wins and restarts the idle count.
        if (ev_q) begin
          we_d       = 1'b1;
          data_d     = pend_q;
          byte_cnt_d = byte_inc;
          idle_cnt_d = '0;
          if (byte_inc == ByteLast) begin
            state_d   = StWait;
            lat_cnt_d = '0;
          end
        end else if (idle_inc == IdleMax) begin
          state_d    = StIdle;
          idle_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      StWait: begin
        // Strobes arriving here are dropped silently.
        if (lat_cnt_q == LatLast) begin
          state_d     = StDone;
          res_data_d  = lgn_out;
          res_valid_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      we_q        <= we_d;
      data_q      <= data_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign lgn_we    = we_q;
  assign lgn_data  = data_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q == StLoad) || (state_q == StWait);

endmodule
